// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the MMIO decoder.
//
// Each rising edge of rx_fin captures rx_byte into a DEPTH-entry circular
// buffer. The oldest byte is shown first-word-fall-through on rx_data. Each
// rising edge of rd_en pops it. A push that arrives while the buffer is full
// and has no matching pop is dropped, and the sticky overrun flag is set.
//
// Ports:
//   clock         system raw clock, all state updates on posedge
//   reset         synchronous, active-high reset
//   rx_byte       receiver byte, captured on an rx_fin rise
//   rx_fin        receiver completion level, one push per rising edge
//   rd_en         decoder read request level, one pop per rising edge
//   clear_overrun single-cycle strobe that clears overrun
//   rx_data       head byte, 8'h00 when empty
//   rx_ready      FIFO non-empty
//   full          count == DEPTH
//   count         number of stored bytes, 0..DEPTH
//   overrun       sticky, a byte was dropped because the FIFO was full
//
// DEPTH must be a power of two and at least 2. The pointers then wrap
// naturally, and the full count is the single top bit of count.

module uart_rx_fifo #(
    parameter int unsigned  DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_fin,
    input  logic              rd_en,
    input  logic              clear_overrun,
    output logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] PtrOne    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   FullCount = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              fin_q, rd_q;

    logic push, pop, empty, is_full;
    logic push_eff, pop_eff, drop;

    always_comb begin
        push    = rx_fin & ~fin_q;
        pop     = rd_en & ~rd_q;
        empty   = (count_q == '0);
        is_full = (count_q == FullCount);
        // A pop that frees a slot lets a push into a full FIFO proceed.
        pop_eff  = pop & ~empty;
        push_eff = push & (~is_full | pop_eff);
        drop     = push & is_full & ~pop_eff;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        if (push_eff && !pop_eff) begin
            count_d = count_q + CntOne;
        end else if (!push_eff && pop_eff) begin
            count_d = count_q - CntOne;
        end

        // If a drop and a clear happen together, the drop wins.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // The edge detectors follow their inputs during reset. A level that is
        // already high at reset release is then not seen as a new edge.
        fin_q <= rx_fin;
        rd_q  <= rd_en;
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset. A write in the same cycle as reset is ignored.
    always_ff @(posedge clock) begin
        if (!reset && push_eff) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    always_comb begin
        rx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
        rx_ready = ~empty;
        full     = is_full;
        count    = count_q;
        overrun  = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
//
// Stimulus tasks drive inputs just after the rising edge. They also update a
// queue-based reference model. Every read request pushes the byte the decoder
// should see into sb_q. A separate monitor samples on the falling edge. When
// it sees the first cycle of an rd_en pulse, it pops sb_q and compares the
// entry with rx_data.

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_fin;
    logic       rd_en;
    logic       clear_overrun;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    // Reference model: stored bytes oldest first, plus the overrun flag.
    logic [7:0] ref_q[$];
    bit         ref_ovr;
    // Bytes the decoder is expected to read, one per issued read request.
    logic [7:0] sb_q[$];

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clock         (clk),
        .reset         (reset),
        .rx_byte       (rx_byte),
        .rx_fin        (rx_fin),
        .rd_en         (rd_en),
        .clear_overrun (clear_overrun),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .full          (full),
        .count         (count),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name);
        chk({name, ".count"}, 32'(count), 32'(ref_q.size()));
        chk({name, ".rx_ready"}, 32'(rx_ready), 32'(ref_q.size() != 0));
        chk({name, ".full"}, 32'(full), 32'(ref_q.size() == DEPTH));
        chk({name, ".overrun"}, 32'(overrun), 32'(ref_ovr));
        chk({name, ".rx_data"}, 32'(rx_data), (ref_q.size() != 0) ? 32'(ref_q[0]) : 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rx_fin        = 1'b0;
        rd_en         = 1'b0;
        clear_overrun = 1'b0;
    endtask

    // Model one edge with the given push, pop and clear events.
    task automatic model_edge(input bit do_push, input logic [7:0] b, input bit do_pop,
                              input bit do_clr);
        bit pop_ok;
        bit dropped;
        pop_ok  = do_pop && (ref_q.size() > 0);
        dropped = 1'b0;
        if (do_pop) sb_q.push_back(pop_ok ? ref_q[0] : 8'h00);
        if (pop_ok) void'(ref_q.pop_front());
        if (do_push) begin
            if (ref_q.size() < DEPTH) ref_q.push_back(b);
            else dropped = 1'b1;
        end
        if (dropped) ref_ovr = 1'b1;
        else if (do_clr) ref_ovr = 1'b0;
    endtask

    // One pulse on the chosen inputs, then one idle cycle, then a state check.
    task automatic op(input string name, input bit do_push, input logic [7:0] b,
                      input bit do_pop, input bit do_clr);
        step();
        rx_fin        = do_push;
        rx_byte       = b;
        rd_en         = do_pop;
        clear_overrun = do_clr;
        model_edge(do_push, b, do_pop, do_clr);
        step();
        drive_idle();
        check_state(name);
    endtask

    // Monitor: the decoder reads rx_data during the first cycle of rd_en.
    initial begin
        logic rd_prev;
        logic [7:0] exp;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && rd_en === 1'b1 && rd_prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("read_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    exp = sb_q.pop_front();
                    chk("read_data", 32'(rx_data), 32'(exp));
                end
            end
            rd_prev = rd_en;
        end
    end

    initial begin
        reset = 1'b1;
        rx_byte = 8'h00;
        drive_idle();
        ref_ovr = 1'b0;
        step();
        step();
        check_state("in_reset");
        reset = 1'b0;
        step();
        check_state("after_reset");

        // Two pushes. Each byte is visible one clock after its edge.
        op("push41", 1'b1, 8'h41, 1'b0, 1'b0);
        op("push42", 1'b1, 8'h42, 1'b0, 1'b0);

        // Holding rd_en for 5 cycles pops exactly one byte.
        step();
        rd_en = 1'b1;
        model_edge(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_state("rd_hold");
        end
        drive_idle();
        op("pop_last", 1'b0, 8'h00, 1'b1, 1'b0);
        op("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // Push 17 bytes: the 17th is dropped and overrun is set.
        for (int i = 0; i <= DEPTH; i++) op("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        // A clear in the same cycle as a dropped push loses to the drop.
        op("clr_vs_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
        op("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        // Overflow again so overrun is set while 5 bytes remain.
        op("refill_drop", 1'b1, 8'hDD, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) op("drain_to5", 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset with count=5 and overrun=1. The push in the same cycle is ignored.
        step();
        reset = 1'b1;
        rx_fin = 1'b1;
        rx_byte = 8'h77;
        ref_q.delete();
        ref_ovr = 1'b0;
        step();
        reset = 1'b0;
        rx_fin = 1'b0;
        check_state("mid_reset");

        // Simultaneous push and pop on an empty FIFO: only the push happens.
        op("both_empty", 1'b1, 8'h5C, 1'b1, 1'b0);
        // Fill to 16, then push and pop together while full.
        for (int i = 1; i < DEPTH; i++) op("fill2", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        op("both_full", 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) op("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Interleaved push and pop across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            op("wrap_push", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            op("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_count_max", 32'(count <= 5'd1), 32'd1);
        end

        // rx_fin held high across reset release must not push.
        step();
        reset = 1'b1;
        rx_fin = 1'b1;
        rx_byte = 8'h99;
        ref_q.delete();
        ref_ovr = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check_state("fin_across_reset");
        rx_fin = 1'b0;
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            op("random", ($urandom_range(0, 99) < 60), 8'($urandom),
               ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 8));
        end

        step();
        step();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
